alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with requester 0 winning.
REQ-002 Parameter DW, default 8, meaning operand and result width; only 8 is supported.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Ports req0/req1  input  1  requester command valid; held until acked.
REQ-006 Ports unit0/unit1  input  1  0 = unit A (alu_op_a), 1 = unit B (alu_op_b).
REQ-007 Ports op0/op1  input  2  operation code for the selected unit.
REQ-008 Ports a0/a1, b0/b1  input  DW  operands.
REQ-009 Ports ack0/ack1  output  1  combinational accept pulse; command latched on that edge.
REQ-010 Ports rsp_valid0/rsp_valid1  output  1  one-cycle response strobe.
REQ-011 Ports rsp_data  output  DW  and rsp_irq  output  1  shared response fields, valid while either rsp_valid is high.
REQ-012 Ports alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr  output  1  ALU control.
REQ-013 Ports alu_op_a, alu_op_b  output  2  and alu_in_a, alu_in_b  output  DW  ALU command.
REQ-014 Ports alu_out  input  DW  and alu_irq  input  1  ALU result.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPT, RESP, with transitions IDLE->ISSUE on any ack, ISSUE->CAPT, CAPT->RESP, RESP->IDLE, all unconditional except the first.
REQ-016 In IDLE, ack is asserted to at most one requester whose req is high, and only in IDLE.
REQ-017 Both req high in IDLE with RR_EN=1: the requester named by the 1-bit pointer wins; the pointer then moves to the loser; the pointer is unchanged when only one requester is served.
REQ-018 RR_EN=0: requester 0 always wins on contention.
REQ-019 On an ack edge the winner's unit, op, a and b are registered, along with the winner id.
REQ-020 In ISSUE only: alu_enable=1; alu_enable_a=~unit; alu_enable_b=unit; the registered op drives the selected alu_op_*, and the other op is 0.
REQ-021 alu_in_a and alu_in_b are driven from the registers in ISSUE and CAPT, and are 0 otherwise.
REQ-022 Exactly one of alu_enable_a/alu_enable_b is high while alu_enable=1; all three are 0 outside ISSUE.
REQ-023 At the CAPT edge, alu_out and alu_irq are registered into rsp_data and rsp_irq.
REQ-024 In RESP, rsp_valid of the stored winner is 1 for exactly one cycle, and rsp_data/rsp_irq are stable.
REQ-025 alu_irq_clr=1 in IDLE and RESP, and 0 in ISSUE and CAPT.
REQ-026 Latency: ack in cycle k gives rsp_valid in cycle k+3; throughput is one command per 4 cycles.
REQ-027 ALU guarded operations (e.g. unit B op 01 with b=0x03) are not filtered; the held alu_out is returned unchanged.
REQ-028 Deasserting req before ack withdraws the request without side effects, and a req arriving outside IDLE waits.

Reset
REQ-029 While rst_n=0 at a clk edge: state goes to IDLE, the pointer goes to 0, and the command and response registers are cleared to 0.
REQ-030 After reset all outputs are 0 except alu_irq_clr, which is 1 (IDLE value).
REQ-031 Reset in any state aborts the transaction: no rsp_valid is produced and the requester is not re-acked.

Structure
REQ-032 Shared package alu_ctrl_pkg SHALL hold: the state enum; UNIT_A/UNIT_B constants; op code constants for both units; and the DW default.
REQ-033 Arbitration SHALL live in one combinational sub-module rr_arb2 (inputs: req[1:0], ptr, rr_en; outputs: gnt[1:0]).

Verification
REQ-034 Bench scenario, single request: req0, unit A, op 10, a=0xF0, b=0x08, ack0 at cycle 0 -> alu_enable high only in cycle 1; rsp_valid0 in cycle 3 with rsp_data=0xF8, rsp_irq=1; alu_irq_clr=1 in cycle 3.
REQ-035 Bench scenario, contention with RR_EN=1 after reset: req0 and req1 both high -> ack0 at cycle 0, ack1 at cycle 4, rsp_valid1 at cycle 7; a repeated contention acks req0 first again.
REQ-036 Bench scenario, fixed priority with RR_EN=0: req0 and req1 held for 12 cycles -> only ack0, at cycles 0, 4 and 8; ack1 stays 0.
REQ-037 Bench scenario, guarded operation: after REQ-034, req1, unit B, op 01, b=0x03 -> rsp_valid1 with rsp_data=0xF8 (held value).
REQ-038 Bench scenario, reset mid-transaction: rst_n=0 during CAPT -> next cycle is IDLE; no rsp_valid for 5 cycles; all ALU drives are 0; alu_irq_clr=1.
REQ-039 Bench scenario, protocol check: across 1000 random commands, alu_enable is high exactly one cycle per ack; the enables are one-hot when active; the rsp_valid count equals the ack count.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command arbiter: FSM states,
// unit selectors, per-unit op codes and the latched command record.
package alu_ctrl_pkg;

  localparam int unsigned ALU_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic UNIT_A = 1'b0;
  localparam logic UNIT_B = 1'b1;

  localparam logic [1:0] OP_A_ADD = 2'b00;
  localparam logic [1:0] OP_A_SUB = 2'b01;
  localparam logic [1:0] OP_A_OR  = 2'b10;
  localparam logic [1:0] OP_A_AND = 2'b11;

  localparam logic [1:0] OP_B_XOR = 2'b00;
  localparam logic [1:0] OP_B_SHR = 2'b01;
  localparam logic [1:0] OP_B_SHL = 2'b10;
  localparam logic [1:0] OP_B_NOT = 2'b11;

  typedef struct packed {
    logic              unit;
    logic [1:0]        op;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic              id;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: round-robin by pointer when rr_en is set,
// otherwise requester 0 wins any contention.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && ptr) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto a shared two-unit ALU: accept in IDLE,
// drive the ALU for one cycle, capture its result, return a one-cycle response.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned DW    = ALU_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          unit0,
  input  logic          unit1,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] b1,
  output logic          ack0,
  output logic          ack1,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_irq,
  output logic          alu_enable,
  output logic          alu_enable_a,
  output logic          alu_enable_b,
  output logic          alu_irq_clr,
  output logic [1:0]    alu_op_a,
  output logic [1:0]    alu_op_b,
  output logic [DW-1:0] alu_in_a,
  output logic [DW-1:0] alu_in_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_irq
);

  localparam logic RR = (RR_EN != 0);

  state_e        state_q;
  logic          ptr_q;
  cmd_t          cmd_q;
  cmd_t          win_cmd;
  logic [1:0]    gnt;
  logic          grant_ok;
  logic          alu_en_q;
  logic          in_vld_q;
  logic          irq_clr_q;
  logic          rsp_v_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_irq_q;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .rr_en (RR),
    .gnt   (gnt)
  );

  // Grants are suppressed during reset so a held request is never latched.
  assign grant_ok = (state_q == IDLE) && rst_n;
  assign ack0     = grant_ok && gnt[0];
  assign ack1     = grant_ok && gnt[1];

  always_comb begin
    win_cmd = '0;
    if (gnt[1]) begin
      win_cmd.unit = unit1;
      win_cmd.op   = op1;
      win_cmd.a    = a1;
      win_cmd.b    = b1;
      win_cmd.id   = 1'b1;
    end else begin
      win_cmd.unit = unit0;
      win_cmd.op   = op0;
      win_cmd.a    = a0;
      win_cmd.b    = b0;
      win_cmd.id   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cmd_q      <= '0;
      alu_en_q   <= 1'b0;
      in_vld_q   <= 1'b0;
      irq_clr_q  <= 1'b1;
      rsp_v_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_irq_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ack0 || ack1) begin
            state_q   <= ISSUE;
            cmd_q     <= win_cmd;
            alu_en_q  <= 1'b1;
            in_vld_q  <= 1'b1;
            irq_clr_q <= 1'b0;
            // Pointer only moves on contention, and always to the loser.
            if (RR && req0 && req1) ptr_q <= ~win_cmd.id;
          end
        end
        ISSUE: begin
          state_q  <= CAPT;
          alu_en_q <= 1'b0;
        end
        CAPT: begin
          state_q    <= RESP;
          in_vld_q   <= 1'b0;
          irq_clr_q  <= 1'b1;
          rsp_v_q    <= 1'b1;
          rsp_data_q <= alu_out;
          rsp_irq_q  <= alu_irq;
        end
        RESP: begin
          state_q <= IDLE;
          rsp_v_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_enable   = alu_en_q;
  assign alu_enable_a = alu_en_q && (cmd_q.unit == UNIT_A);
  assign alu_enable_b = alu_en_q && (cmd_q.unit == UNIT_B);
  assign alu_op_a     = alu_enable_a ? cmd_q.op : '0;
  assign alu_op_b     = alu_enable_b ? cmd_q.op : '0;
  assign alu_in_a     = in_vld_q ? cmd_q.a : '0;
  assign alu_in_b     = in_vld_q ? cmd_q.b : '0;
  assign alu_irq_clr  = irq_clr_q;
  assign rsp_valid0   = rsp_v_q && !cmd_q.id;
  assign rsp_valid1   = rsp_v_q && cmd_q.id;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus random traffic for alu_arbiter, checked against a
// transaction-level reference (latency, arbitration rules, ALU result).
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, unit0, unit1;
  logic [1:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic       ack0, ack1, rsp_valid0, rsp_valid1, rsp_irq;
  logic [7:0] rsp_data;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic       alu_irq;

  logic       f_req0, f_req1;
  logic       f_ack0, f_ack1, f_rv0, f_rv1, f_rirq;
  logic [7:0] f_rdata, f_in_a, f_in_b;
  logic       f_en, f_en_a, f_en_b, f_clr;
  logic [1:0] f_op_a, f_op_b;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .unit0(unit0), .unit1(unit1),
    .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_irq(rsp_irq),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_irq_clr(alu_irq_clr), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_out(alu_out), .alu_irq(alu_irq)
  );

  alu_arbiter #(.RR_EN(0), .DW(8)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .req1(f_req1), .unit0(1'b0), .unit1(1'b1),
    .op0(2'b00), .op1(2'b00), .a0(8'h00), .a1(8'h00), .b0(8'h00), .b1(8'h00),
    .ack0(f_ack0), .ack1(f_ack1), .rsp_valid0(f_rv0), .rsp_valid1(f_rv1),
    .rsp_data(f_rdata), .rsp_irq(f_rirq),
    .alu_enable(f_en), .alu_enable_a(f_en_a), .alu_enable_b(f_en_b),
    .alu_irq_clr(f_clr), .alu_op_a(f_op_a), .alu_op_b(f_op_b),
    .alu_in_a(f_in_a), .alu_in_b(f_in_b), .alu_out(8'h00), .alu_irq(1'b0)
  );

  function automatic logic [7:0] alu_fn(input logic unit, input logic [1:0] op,
                                        input logic [7:0] a, input logic [7:0] b);
    if (unit == UNIT_A) begin
      case (op)
        OP_A_ADD: return a + b;
        OP_A_SUB: return a - b;
        OP_A_OR:  return a | b;
        default:  return a & b;
      endcase
    end else begin
      case (op)
        OP_B_XOR: return a ^ b;
        OP_B_SHR: return a >> b[2:0];
        OP_B_SHL: return a << b[2:0];
        default:  return ~a;
      endcase
    end
  endfunction

  // The stub ALU refuses an odd shift-right amount and keeps its last result.
  function automatic logic guarded(input logic unit, input logic [1:0] op, input logic [7:0] b);
    return (unit == UNIT_B) && (op == OP_B_SHR) && b[0];
  endfunction

  logic [7:0] alu_res = 8'h00;
  always @(posedge clk) begin
    if (alu_enable && !guarded(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_b))
      alu_res <= alu_fn(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b);
  end
  assign alu_out = alu_res;
  assign alu_irq = alu_res[7];

  int         checks = 0, failures = 0;
  int         cyc = 0, last_ack = -100;
  logic       ptr = 1'b0;
  logic       m_unit = 1'b0, m_id = 1'b0;
  logic [1:0] m_op = 2'b00;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, alu_ref = 8'h00;
  logic       keep_req = 1'b0;
  logic [1:0] acked = 2'b00;
  int         ack_total = 0, en_total = 0, rsp_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic eval();
    int         ph;
    logic [1:0] r, w;
    #1;
    ph = cyc - last_ack;
    r  = {req1, req0};
    w  = 2'b00;
    if (ph >= 4 && rst_n) w = (r == 2'b11) ? (ptr ? 2'b10 : 2'b01) : r;
    chk("ack0", ack0, w[0]);
    chk("ack1", ack1, w[1]);
    chk("alu_enable", alu_enable, ph == 1);
    chk("alu_enable_a", alu_enable_a, ph == 1 && m_unit == UNIT_A);
    chk("alu_enable_b", alu_enable_b, ph == 1 && m_unit == UNIT_B);
    chk("alu_op_a", alu_op_a, (ph == 1 && m_unit == UNIT_A) ? m_op : 2'b00);
    chk("alu_op_b", alu_op_b, (ph == 1 && m_unit == UNIT_B) ? m_op : 2'b00);
    chk("alu_in_a", alu_in_a, (ph == 1 || ph == 2) ? m_a : 8'h00);
    chk("alu_in_b", alu_in_b, (ph == 1 || ph == 2) ? m_b : 8'h00);
    chk("alu_irq_clr", alu_irq_clr, !(ph == 1 || ph == 2));
    chk("rsp_valid0", rsp_valid0, ph == 3 && !m_id);
    chk("rsp_valid1", rsp_valid1, ph == 3 && m_id);
    if (ph == 3) begin
      chk("rsp_data", rsp_data, alu_ref);
      chk("rsp_irq", rsp_irq, alu_ref[7]);
    end
    if (alu_enable) begin
      en_total++;
      chk("enable_onehot", alu_enable_a ^ alu_enable_b, 1'b1);
    end
    if (rsp_valid0 || rsp_valid1) rsp_total++;
    acked = w;
    if (w != 2'b00) begin
      ack_total++;
      last_ack = cyc;
      m_id     = w[1];
      m_unit   = w[1] ? unit1 : unit0;
      m_op     = w[1] ? op1 : op0;
      m_a      = w[1] ? a1 : a0;
      m_b      = w[1] ? b1 : b0;
      if (r == 2'b11) ptr = ~m_id;
      if (!guarded(m_unit, m_op, m_b)) alu_ref = alu_fn(m_unit, m_op, m_a, m_b);
    end
  endtask

  task automatic advance();
    logic rs;
    rs = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rs) begin
      last_ack = -100;
      ptr      = 1'b0;
    end
    if (!keep_req) begin
      if (acked[0]) req0 = 1'b0;
      if (acked[1]) req1 = 1'b0;
    end
    acked = 2'b00;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
    rst_n = 1'b0;
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic u, input logic [1:0] o,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin req0 = 1'b1; unit0 = u; op0 = o; a0 = a; b0 = b; end
    else         begin req1 = 1'b1; unit1 = u; op1 = o; a1 = a; b1 = b; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_ack, base_en, base_rsp;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; unit0 = 0; unit1 = 0; op0 = 0; op1 = 0;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0; f_req0 = 0; f_req1 = 0;

    do_reset();
    eval();
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_irq", rsp_irq, 1'b0);
    chk("rst_fp_ack0", f_ack0, 1'b0);
    chk("rst_fp_clr", f_clr, 1'b1);
    advance();

    // Single request on unit A: OR gives 0xF8 with irq from bit 7.
    set_req(0, UNIT_A, OP_A_OR, 8'hF0, 8'h08);
    for (int k = 0; k < 4; k++) begin
      eval();
      if (k == 0) chk("s1_ack0", ack0, 1'b1);
      if (k == 1) chk("s1_enable", alu_enable, 1'b1);
      if (k == 3) begin
        chk("s1_rsp_valid0", rsp_valid0, 1'b1);
        chk("s1_rsp_data", rsp_data, 8'hF8);
        chk("s1_rsp_irq", rsp_irq, 1'b1);
        chk("s1_irq_clr", alu_irq_clr, 1'b1);
      end
      advance();
    end

    // Guarded unit B op returns the held ALU value.
    set_req(1, UNIT_B, OP_B_SHR, 8'h55, 8'h03);
    for (int k = 0; k < 4; k++) begin
      eval();
      if (k == 3) begin
        chk("g_rsp_valid1", rsp_valid1, 1'b1);
        chk("g_rsp_data", rsp_data, 8'hF8);
      end
      advance();
    end

    // Contention with round-robin, both requesters re-requesting continuously.
    do_reset();
    keep_req = 1'b1;
    set_req(0, UNIT_A, OP_A_ADD, 8'h11, 8'h22);
    set_req(1, UNIT_B, OP_B_XOR, 8'h3C, 8'hFF);
    for (int k = 0; k < 12; k++) begin
      eval();
      if (k == 0) chk("rr_ack0_c0", ack0, 1'b1);
      if (k == 4) chk("rr_ack1_c4", ack1, 1'b1);
      if (k == 7) chk("rr_rsp_valid1_c7", rsp_valid1, 1'b1);
      if (k == 8) chk("rr_ack0_c8", ack0, 1'b1);
      advance();
    end
    keep_req = 1'b0;
    req0 = 1'b0; req1 = 1'b0;

    // Fixed priority instance: requester 0 always wins.
    f_req0 = 1'b1; f_req1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      eval();
      chk("fp_ack0", f_ack0, (k % 4) == 0);
      chk("fp_ack1", f_ack1, 1'b0);
      advance();
    end
    f_req0 = 1'b0; f_req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin eval(); advance(); end

    // Reset during CAPT aborts the transaction.
    set_req(0, UNIT_A, OP_A_SUB, 8'h10, 8'h01);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rst_n = 1'b0;
      eval();
      advance();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("mr_rsp_valid0", rsp_valid0, 1'b0);
      chk("mr_alu_enable", alu_enable, 1'b0);
      chk("mr_alu_in_a", alu_in_a, 8'h00);
      chk("mr_irq_clr", alu_irq_clr, 1'b1);
      chk("mr_ack0", ack0, 1'b0);
      advance();
    end

    // Random traffic with occasional withdrawal.
    base_ack = ack_total; base_en = en_total; base_rsp = rsp_total;
    for (int c = 0; c < 20000 && (ack_total - base_ack) < 1000; c++) begin
      if (req0 && $urandom_range(0, 19) == 0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0)
        set_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      if (req1 && $urandom_range(0, 19) == 0) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0)
        set_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      eval();
      advance();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin eval(); advance(); end
    chk("rand_reached_1000", (ack_total - base_ack) >= 1000, 1'b1);
    chk("rand_enable_count", en_total - base_en, ack_total - base_ack);
    chk("rand_rsp_count", rsp_total - base_rsp, ack_total - base_ack);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
